decode_ctrl_pipe: RTL

Registered main-decoder and ID/EX control stage for the RV32IM pipelined core. It decodes the 32-bit instruction in ID into the datapath control set and captures it into an ID/EX control register. Stall and flush control that register, and optional M-extension decode is selected by parameter. A small FSM holds the pipeline for multi-cycle multiply/divide operations.

---
 rtl/decode_ctrl_pipe.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/decode_ctrl_pipe.sv
// RV32IM main decoder feeding a registered ID/EX control stage, with a small
// IDLE/BUSY sequencer that holds ID while a multi-cycle multiply/divide occupies EX.
module decode_ctrl_pipe #(
  parameter bit          ENABLE_M   = 1'b1,
  parameter int unsigned MUL_CYCLES = 1,
  parameter int unsigned DIV_CYCLES = 33
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid_i,
  input  logic [31:0] instr_i,
  input  logic        stall_i,
  input  logic        flush_i,
  output logic        id_stall_o,
  output logic        ex_valid_o,
  output logic        ex_illegal_o,
  output logic        ex_reg_write_o,
  output logic [4:0]  ex_alu_control_o,
  output logic        ex_alu_src_a_o,
  output logic        ex_alu_src_b_o,
  output logic        ex_mem_write_o,
  output logic [1:0]  ex_result_src_o,
  output logic        ex_branch_o,
  output logic [2:0]  ex_branch_type_o,
  output logic [1:0]  ex_jump_o,
  output logic [2:0]  ex_imm_src_o,
  output logic [2:0]  ex_addr_ctrl_o
);

  typedef struct packed {
    logic       valid;
    logic       illegal;
    logic       reg_write;
    logic [4:0] alu_control;
    logic       alu_src_a;
    logic       alu_src_b;
    logic       mem_write;
    logic [1:0] result_src;
    logic       branch;
    logic [2:0] branch_type;
    logic [1:0] jump;
    logic [2:0] imm_src;
    logic [2:0] addr_ctrl;
  } ctrl_t;

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [4:0] ALU_ADD = 5'b00000, ALU_SUB = 5'b00001, ALU_AND = 5'b00010,
                         ALU_OR  = 5'b00011, ALU_XOR = 5'b00100, ALU_SLL = 5'b00101,
                         ALU_SRL = 5'b00110, ALU_SRA = 5'b00111, ALU_SLT = 5'b01000,
                         ALU_SLTU = 5'b01001, ALU_LUI = 5'b01111;
  localparam logic [5:0] MUL_N = 6'(MUL_CYCLES);
  localparam logic [5:0] DIV_N = 6'(DIV_CYCLES);

  // Shared by R-type and OP-IMM; alt selects sub/sra where funct7 asks for it.
  function automatic logic [4:0] alu_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  alu_op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  alu_op = ALU_SLL;
      3'b010:  alu_op = ALU_SLT;
      3'b011:  alu_op = ALU_SLTU;
      3'b100:  alu_op = ALU_XOR;
      3'b101:  alu_op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  alu_op = ALU_OR;
      default: alu_op = ALU_AND;
    endcase
  endfunction

  logic [6:0] opcode, f7;
  logic [2:0] f3;
  logic       legal, m_op;
  logic [5:0] n_cycles;
  ctrl_t      dec, ex_q, ex_n;
  state_t     state_q, state_n;
  logic [5:0] cnt_q, cnt_n;
  logic       unused_bits;

  assign opcode      = instr_i[6:0];
  assign f3          = instr_i[14:12];
  assign f7          = instr_i[31:25];
  assign unused_bits = ^{instr_i[24:15], instr_i[11:7]};

  always_comb begin
    // NOTE: every field gets a default before the case so no path infers a latch.
    dec   = '0;
    legal = 1'b1;
    case (opcode)
      7'b0110011: begin
        dec.reg_write = 1'b1;
        case (f7)
          7'b0000000: dec.alu_control = alu_op(f3, 1'b0);
          7'b0100000: begin
            legal           = (f3 == 3'b000) || (f3 == 3'b101);
            dec.alu_control = alu_op(f3, 1'b1);
          end
          7'b0000001: begin
            legal           = ENABLE_M;
            dec.alu_control = {2'b10, f3};
          end
          default:    legal = 1'b0;
        endcase
      end
      7'b0010011: begin
        dec.reg_write   = 1'b1;
        dec.alu_src_b   = 1'b1;
        dec.alu_control = alu_op(f3, (f3 == 3'b101) && f7[5]);
        if (f3 == 3'b001)      legal = (f7 == 7'b0000000);
        else if (f3 == 3'b101) legal = (f7 == 7'b0000000) || (f7 == 7'b0100000);
      end
      7'b0000011: begin
        dec.reg_write  = 1'b1;
        dec.alu_src_b  = 1'b1;
        dec.result_src = 2'b01;
        dec.addr_ctrl  = f3;
        legal          = (f3 != 3'b011) && (f3 [2:1] != 2'b11);
      end
      7'b0100011: begin
        dec.mem_write = 1'b1;
        dec.alu_src_b = 1'b1;
        dec.imm_src   = 3'b001;
        dec.addr_ctrl = f3;
        legal         = (f3[2] == 1'b0) && (f3 != 3'b011);
      end
      7'b1100011: begin
        dec.branch      = 1'b1;
        dec.imm_src     = 3'b010;
        dec.branch_type = f3;
        legal           = (f3[2:1] != 2'b01);
        dec.alu_control = !f3[2] ? ALU_SUB : (f3[1] ? ALU_SLTU : ALU_SLT);
      end
      7'b1101111: begin
        dec.reg_write  = 1'b1;
        dec.result_src = 2'b10;
        dec.imm_src    = 3'b011;
        dec.jump       = 2'b01;
      end
      7'b1100111: begin
        dec.reg_write  = 1'b1;
        dec.alu_src_b  = 1'b1;
        dec.result_src = 2'b10;
        dec.jump       = 2'b10;
        legal          = (f3 == 3'b000);
      end
      7'b0110111: begin
        dec.reg_write   = 1'b1;
        dec.alu_src_b   = 1'b1;
        dec.imm_src     = 3'b100;
        dec.alu_control = ALU_LUI;
      end
      7'b0010111: begin
        dec.reg_write = 1'b1;
        dec.alu_src_a = 1'b1;
        dec.alu_src_b = 1'b1;
        dec.imm_src   = 3'b100;
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      dec         = '0;
      dec.illegal = 1'b1;
    end else begin
      dec.valid = 1'b1;
    end
  end

  assign m_op       = dec.valid && (opcode == 7'b0110011) && (f7 == 7'b0000001);
  assign n_cycles   = f3[2] ? DIV_N : MUL_N;
  assign id_stall_o = stall_i || (state_q == BUSY);

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    ex_n    = ex_q;
    if (flush_i) begin
      ex_n    = '0;
      state_n = IDLE;
      cnt_n   = '0;
    end else if (id_stall_o) begin
      // The busy countdown keeps running even while stall_i also holds ID.
      if (state_q == BUSY) begin
        if (cnt_q == '0) state_n = IDLE;
        else             cnt_n   = cnt_q - 6'd1;
      end
    end else begin
      ex_n = instr_valid_i ? dec : '0;
      if (instr_valid_i && m_op && (n_cycles > 6'd1)) begin
        state_n = BUSY;
        cnt_n   = n_cycles - 6'd2;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignment so all registers update together.
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ex_q    <= '0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      ex_q    <= ex_n;
    end
  end

  assign ex_valid_o       = ex_q.valid;
  assign ex_illegal_o     = ex_q.illegal;
  assign ex_reg_write_o   = ex_q.reg_write;
  assign ex_alu_control_o = ex_q.alu_control;
  assign ex_alu_src_a_o   = ex_q.alu_src_a;
  assign ex_alu_src_b_o   = ex_q.alu_src_b;
  assign ex_mem_write_o   = ex_q.mem_write;
  assign ex_result_src_o  = ex_q.result_src;
  assign ex_branch_o      = ex_q.branch;
  assign ex_branch_type_o = ex_q.branch_type;
  assign ex_jump_o        = ex_q.jump;
  assign ex_imm_src_o     = ex_q.imm_src;
  assign ex_addr_ctrl_o   = ex_q.addr_ctrl;

endmodule
